traffic_fsm: RTL and testbench
==============================

Name: traffic_fsm

Overview:
Two-way (North-South / East-West) intersection signal controller built as a 4-state Moore FSM with one cycle timer.
- Grants green to one approach at a time.
- Honours a minimum green time and a maximum green time (fairness cap).
- Inserts an all-red interlock interval on every handover.
- Sits between the car-presence sensor inputs and the lamp drivers.

Parameters:
MIN_GREEN_CYCLES, 20, minimum green duration in clock cycles (>=1).
MAX_GREEN_CYCLES, 60, maximum green duration in cycles (>= MIN_GREEN_CYCLES).
ALL_RED_CYCLES, 4, all-red interlock duration in cycles (>=1).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
cars_ns  input  1  level request: vehicles waiting on the N-S approach; synchronous to clk.
cars_ew  input  1  level request: vehicles waiting on the E-W approach; synchronous to clk.
green_N  output  1  N-S green lamp.
red_N  output  1  N-S red lamp.
green_E  output  1  E-W green lamp.
red_E  output  1  E-W red lamp.

Behaviour:
- Internal registers, named exactly for bench visibility:
  - state (2 bits): 0=NS_GREEN, 1=ALLRED_TO_EW, 2=EW_GREEN, 3=ALLRED_TO_NS.
  - timer: width $clog2(MAX_GREEN_CYCLES+1), minimum 1.
- Reset (rst=0, asynchronous): state=NS_GREEN, timer=0.
  - Outputs immediately green_N=1, red_N=0, green_E=0, red_E=1.
  - Reset asserted mid-operation aborts the current state and restarts the controller in the same way.
- Timer:
  - Cleared to 0 on every state transition.
  - Otherwise increments by 1 per cycle.
  - Never wraps: transitions always fire before the timer would exceed MAX_GREEN_CYCLES-1.
- Outputs are Moore, decoded from state only:
  - green_N=1 only in NS_GREEN; red_N = ~green_N.
  - green_E=1 only in EW_GREEN; red_E = ~green_E.
  - green_N and green_E are never both 1.
  - Both reds are 1 in the two all-red states.
- NS_GREEN to ALLRED_TO_EW happens at the clock edge where either condition holds:
  - (a) timer >= MIN_GREEN_CYCLES-1 and cars_ew=1 and cars_ns=0; or
  - (b) timer == MAX_GREEN_CYCLES-1, regardless of requests.
- EW_GREEN to ALLRED_TO_NS uses the same rule with the NS/EW roles swapped.
- Consequences of the green rules:
  - Green lasts at least MIN_GREEN_CYCLES and at most MAX_GREEN_CYCLES cycles.
  - With no requests, the approaches alternate every MAX_GREEN_CYCLES cycles.
  - With both sides requesting, the serving side keeps green until MAX_GREEN_CYCLES, then hands over.
- ALLRED_TO_EW to EW_GREEN, and ALLRED_TO_NS to NS_GREEN: at the edge where timer == ALL_RED_CYCLES-1, so all-red lasts exactly ALL_RED_CYCLES cycles.
- Requests are sampled as levels each cycle and are not latched.
  - A request dropped before the minimum is reached causes no early switch.
  - Requests during all-red have no effect.
- Invalid state encodings cannot occur. If one is ever reached, the next state is ALLRED_TO_NS with timer=0.

Test Plan (bench overrides MIN=8, MAX=24, ALL_R=3):
1. Reset low 2 cycles, then release with no requests:
   - During reset: state=0, green_N=1, red_E=1.
   - After release: NS green held 24 cycles, then state=1 for 3 cycles, then state=2 with green_E=1, red_N=1.
2. cars_ew=1 raised while NS green at timer=4:
   - Switch to all-red at the edge where timer=7 (8 green cycles total).
   - 3 all-red cycles, then EW green.
   - green_N and green_E never simultaneously 1.
3. EW green, cars_ew dropped, no requests: EW green lasts exactly 24 cycles, then 3 all-red cycles, then NS green.
4. cars_ns=1 and cars_ew=0 while EW green with timer>=7: all-red at the next edge, then NS green 3 cycles later.
5. cars_ns=cars_ew=1 held for 30+ cycles:
   - Serving side stays green until timer=23, then hands over.
   - Alternation continues at 24-cycle greens.
6. Assert rst=0 asynchronously mid all-red (state=1, timer=1): outputs return to NS green immediately, without waiting for a clock edge, and timer=0.

Source files
------------

// File: rtl/traffic_fsm.sv
`default_nettype none
// ============================================================================
// Module      : traffic_fsm
// Description : Two-way (N-S / E-W) intersection signal controller. A 4-state
//               Moore FSM with a single cycle timer grants green to one
//               approach at a time, honours a minimum and maximum green time,
//               and inserts an all-red interlock interval on every handover.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_fsm #(
  parameter int MIN_GREEN_CYCLES = 20,  // >= 1
  parameter int MAX_GREEN_CYCLES = 60,  // >= MIN_GREEN_CYCLES
  parameter int ALL_RED_CYCLES   = 4    // >= 1, <= MAX_GREEN_CYCLES + 1
) (
  input  logic clk,
  input  logic rst,       // asynchronous, active-low
  input  logic cars_ns,
  input  logic cars_ew,
  output logic green_N,
  output logic red_N,
  output logic green_E,
  output logic red_E
);

  // Timer only has to count up to MAX_GREEN_CYCLES-1; keep at least one bit.
  localparam int TIMER_W_RAW = $clog2(MAX_GREEN_CYCLES + 1);
  localparam int TIMER_W     = (TIMER_W_RAW < 1) ? 1 : TIMER_W_RAW;

  // Last timer value of each interval: the transition fires on that edge.
  localparam logic [TIMER_W-1:0] MIN_LAST    = TIMER_W'(MIN_GREEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MAX_LAST    = TIMER_W'(MAX_GREEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALL_RED_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO  = '0;

  typedef enum logic [1:0] {
    NS_GREEN     = 2'd0,
    ALLRED_TO_EW = 2'd1,
    EW_GREEN     = 2'd2,
    ALLRED_TO_NS = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [TIMER_W-1:0] timer;

  // Timer milestones shared by both green states and both all-red states.
  logic min_reached;
  logic max_reached;
  logic allred_done;

  // A green side yields early only when the other side waits and its own
  // side is idle; the max cap forces a handover regardless of requests.
  logic ns_yield;
  logic ew_yield;

  // Timer milestone decode.
  always_comb begin
    min_reached = (timer >= MIN_LAST);
    max_reached = (timer == MAX_LAST);
    allred_done = (timer == ALLRED_LAST);
    ns_yield    = (min_reached && cars_ew && !cars_ns) || max_reached;
    ew_yield    = (min_reached && cars_ns && !cars_ew) || max_reached;
  end

  // State register: reset restarts the controller in N-S green.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NS_GREEN;
    end else begin
      state <= next_state;
    end
  end

  // Cycle timer: cleared on every state change, otherwise counts up. The
  // green and all-red rules guarantee a transition before it could wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= TIMER_ZERO;
    end else if (next_state != state) begin
      timer <= TIMER_ZERO;
    end else begin
      timer <= timer + TIMER_ONE;
    end
  end

  // Next-state logic. Requests are plain levels, ignored during all-red.
  always_comb begin
    next_state = state;
    case (state)
      NS_GREEN: begin
        if (ns_yield) begin
          next_state = ALLRED_TO_EW;
        end
      end
      ALLRED_TO_EW: begin
        if (allred_done) begin
          next_state = EW_GREEN;
        end
      end
      EW_GREEN: begin
        if (ew_yield) begin
          next_state = ALLRED_TO_NS;
        end
      end
      ALLRED_TO_NS: begin
        if (allred_done) begin
          next_state = NS_GREEN;
        end
      end
      // Unreachable with a 2-bit encoding; recover through an all-red phase.
      default: begin
        next_state = ALLRED_TO_NS;
      end
    endcase
  end

  // Moore lamp decode: each red is simply the inverse of its green, so the
  // two greens can never be on together and all-red lights both reds.
  always_comb begin
    green_N = (state == NS_GREEN);
    green_E = (state == EW_GREEN);
    red_N   = ~green_N;
    red_E   = ~green_E;
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_fsm
// Description : Scoreboard bench for traffic_fsm. A stimulus process drives
//               request levels and pushes the expected per-cycle result of a
//               phase/elapsed-time reference model into a queue; a monitor
//               process pops and compares on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_fsm;

  localparam int MIN  = 8;
  localparam int MAX  = 24;
  localparam int ALLR = 3;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic cars_ns = 1'b0;
  logic cars_ew = 1'b0;
  logic green_N;
  logic red_N;
  logic green_E;
  logic red_E;

  traffic_fsm #(
    .MIN_GREEN_CYCLES (MIN),
    .MAX_GREEN_CYCLES (MAX),
    .ALL_RED_CYCLES   (ALLR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cars_ns (cars_ns),
    .cars_ew (cars_ew),
    .green_N (green_N),
    .red_N   (red_N),
    .green_E (green_E),
    .red_E   (red_E)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Expected observation for one cycle: phase (0=NS green, 1=all-red to EW,
  // 2=EW green, 3=all-red to NS) and cycles already spent in that phase.
  typedef struct {
    int phase;
    int served;
  } exp_t;

  exp_t q[$];

  int   m_phase  = 0;
  int   m_served = 0;
  int   timeouts = 0;
  bit   stim_done = 1'b0;
  int   async_cnt = 0;
  event async_chk;

  int n_checks = 0;
  int n_fails  = 0;

  // ---------------------------------------------------------------- model
  // Advance the reference model by one clock edge using the levels present.
  task automatic model_edge();
    int   done;
    bit   leave;
    logic mine;
    logic other;
    if (!rst) begin
      m_phase  = 0;
      m_served = 0;
      return;
    end
    done = m_served + 1;  // length of the phase if it ends at this edge
    if (m_phase == 0 || m_phase == 2) begin
      mine  = (m_phase == 0) ? cars_ns : cars_ew;
      other = (m_phase == 0) ? cars_ew : cars_ns;
      leave = (done >= MIN && other && !mine) || (done == MAX);
    end else begin
      leave = (done == ALLR);
    end
    if (leave) begin
      m_phase  = (m_phase + 1) % 4;
      m_served = 0;
    end else begin
      m_served = done;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.phase  = m_phase;
    e.served = m_served;
    q.push_back(e);
  endtask

  // Apply request levels for the next edge, then update the model after it.
  task automatic cycle(input logic ns, input logic ew);
    cars_ns = ns;
    cars_ew = ew;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic run(input logic ns, input logic ew, input int n);
    repeat (n) begin
      cycle(ns, ew);
      push_exp();
    end
  endtask

  // Step until the model reaches the target phase with served in [lo,hi].
  // When push_hit is clear the matching cycle's expectation is withheld so
  // the caller can disturb that cycle (asynchronous reset).
  task automatic run_until(input logic ns, input logic ew, input int ph,
                           input int lo, input int hi, input int limit,
                           input bit push_hit);
    for (int i = 0; i < limit; i++) begin
      cycle(ns, ew);
      if (m_phase == ph && m_served >= lo && m_served <= hi) begin
        if (push_hit) push_exp();
        return;
      end
      push_exp();
    end
    timeouts++;
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    // 1: reset for two cycles, then no requests through a full handover.
    run(1'b0, 1'b0, 2);
    rst = 1'b1;
    run(1'b0, 1'b0, 40);

    // 2: E-W request raised while N-S green at timer 4.
    run_until(1'b0, 1'b0, 0, 4, 4, 100, 1'b1);
    run(1'b0, 1'b1, 14);

    // 3: requests dropped during E-W green: max-length green then handover.
    run(1'b0, 1'b0, 60);

    // 4: N-S only request while E-W green past the minimum.
    run_until(1'b0, 1'b0, 2, 7, MAX, 100, 1'b1);
    run(1'b1, 1'b0, 8);

    // 5: both sides requesting: greens run to the cap and alternate.
    run(1'b1, 1'b1, 80);

    // Randomised request levels held for random durations.
    repeat (40) begin
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(1, 30)));
    end

    // 6: asynchronous reset in the middle of all-red (state 1, timer 1).
    run_until(1'b0, 1'b1, 1, 1, 1, 200, 1'b0);
    #1 rst = 1'b0;
    #1;
    async_cnt++;
    -> async_chk;
    m_phase  = 0;
    m_served = 0;
    push_exp();
    run(1'b0, 1'b1, 1);
    rst = 1'b1;
    run(1'b0, 1'b1, 30);
    run(1'b0, 1'b0, 30);

    repeat (2) @(posedge clk);
    stim_done = 1'b1;
  end

  // --------------------------------------------------------------- monitor
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    int   seen_async;
    seen_async = 0;
    forever begin
      @(negedge clk or async_chk);
      if (async_cnt != seen_async) begin
        // Reset asserted between clock edges: outputs must already be reset.
        seen_async = async_cnt;
        chk("async_green_N", int'(green_N), 1);
        chk("async_red_N",   int'(red_N),   0);
        chk("async_green_E", int'(green_E), 0);
        chk("async_red_E",   int'(red_E),   1);
        chk("async_state",   int'(dut.state), 0);
        chk("async_timer",   int'(dut.timer), 0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("state",   int'(dut.state), e.phase);
        chk("timer",   int'(dut.timer), e.served);
        chk("green_N", int'(green_N), (e.phase == 0) ? 1 : 0);
        chk("red_N",   int'(red_N),   (e.phase == 0) ? 0 : 1);
        chk("green_E", int'(green_E), (e.phase == 2) ? 1 : 0);
        chk("red_E",   int'(red_E),   (e.phase == 2) ? 0 : 1);
        chk("greens_exclusive", int'(green_N & green_E), 0);
      end
      if (stim_done && q.size() == 0) break;
    end
    chk("wait_timeouts", timeouts, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
